// File: rtl/maxpool_ctrl_if.sv
`default_nettype none
// ============================================================================
// maxpool_ctrl_if : pixel-stream handshake and pooling-datapath control bundle
// Revision: 1.0
// ============================================================================
interface maxpool_ctrl_if #(
  parameter int COL_W = 5
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic             lb_wr_en;
  logic [COL_W-1:0] lb_addr;
  logic             h_en;
  logic             v_en;
  logic             o_en;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, out_valid, lb_wr_en, lb_addr, h_en, v_en, o_en, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, out_valid, lb_wr_en, lb_addr, h_en, v_en, o_en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/maxpool_ctrl.sv
`default_nettype none
// ============================================================================
// maxpool_ctrl : sequencer for a 2x2/stride-2 max-pool datapath (enables, line
//                buffer, output handshake). MAXPOOL_CTRL_OUT_CNT_EN adds out_cnt_o.
// Revision: 1.0
// ============================================================================
module maxpool_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int COL_W  = 5,
  parameter int ROW_W  = 5,
  parameter int OCNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  maxpool_ctrl_if.slave    bus
`ifdef MAXPOOL_CTRL_OUT_CNT_EN
  ,
  output logic [OCNT_W-1:0] out_cnt_o
`endif
);

  generate
    if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
      $error("maxpool_ctrl: IMG_W must be even and >= 2");
    end
    if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
      $error("maxpool_ctrl: IMG_H must be even and >= 2");
    end
    if (((1 << COL_W) < IMG_W) || ((1 << ROW_W) < IMG_H) || (COL_W < 2)) begin : g_bad_cnt_w
      $error("maxpool_ctrl: COL_W/ROW_W too narrow for image size");
    end
    if (OCNT_W < 1) begin : g_bad_ocnt_w
      $error("maxpool_ctrl: OCNT_W must be >= 1");
    end
  endgenerate

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             out_valid_q, out_valid_d;

  logic w_in_ready;
  logic w_accept;
  logic w_v_en;
  logic w_o_en;

  // Stall while an unconsumed pooled value would be overwritten by a new window.
  assign w_in_ready = (state_q == S_RUN) & ~(out_valid_q & ~bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_v_en     = w_accept & col_q[0];
  assign w_o_en     = w_v_en & row_q[0];

  assign bus.in_ready  = w_in_ready;
  assign bus.h_en      = w_accept & ~col_q[0];
  assign bus.v_en      = w_v_en;
  assign bus.o_en      = w_o_en;
  assign bus.lb_wr_en  = w_v_en & ~row_q[0];
  assign bus.lb_addr   = {1'b0, col_q[COL_W-1:1]};
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == S_RUN) | (state_q == S_FLUSH);
  assign bus.done      = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = w_o_en | (out_valid_q & ~bus.out_ready);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (col_q == c_COL_LAST) begin
            col_d = '0;
            if (row_q == c_ROW_LAST) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (~out_valid_q | bus.out_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MAXPOOL_CTRL_OUT_CNT_EN
  logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if ((state_q == S_IDLE) & bus.start) begin
      out_cnt_d = '0;
    end else if (out_valid_q & bus.out_ready) begin
      out_cnt_d = out_cnt_q + OCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_cnt_q <= '0;
    else     out_cnt_q <= out_cnt_d;
  end

  assign out_cnt_o = out_cnt_q;
`endif

endmodule
`default_nettype wire
